// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the instruction/data memory port arbiter
//
// Purpose: state and owner encodings used by imem_dmem_arbiter.
// Ports:   none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - shares one memsystem port between fetch (I) and memory stage (D)
//
// Purpose: grants one transaction at a time to either the fetch port or the data port,
//          holds the memsystem request stable until mem_data_valid, then returns read data
//          and a one-cycle done pulse to the owner. D has priority; I is forced after
//          STARVE_LIMIT consecutive D grants made while I was waiting.
// Ports:
//   clk, rst_n                            clock, asynchronous active-low reset
//   if_req, if_addr                       fetch read request (level) and address
//   if_rdata, if_done                     fetch read data and completion pulse
//   d_req, d_wr, d_addr, d_wdata          data request (level), direction, address, write data
//   d_rdata, d_done                       data read data and completion pulse
//   mem_en, mem_wr, mem_addr, mem_wdata   memsystem request (registered, held during GRANT)
//   mem_data_valid, mem_rdata             memsystem completion and read data
//   busy                                  high in every state except IDLE
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  arb_owner_t       owner;
  logic [CNT_W-1:0] starve_cnt;
  logic             pick_d;

  // D is the older instruction and normally wins; once I has watched LIMIT D grants
  // go by while waiting, I is forced through.
  function automatic logic select_d(input logic i_req, input logic dreq,
                                    input logic [CNT_W-1:0] cnt);
    return dreq && !(i_req && (cnt == LIMIT));
  endfunction

  assign pick_d = select_d(if_req, d_req, starve_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_I;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Done pulses last exactly one cycle (the RESP cycle).
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state  <= GRANT;
            mem_en <= 1'b1;
            busy   <= 1'b1;
            if (pick_d) begin
              owner     <= OWN_D;
              mem_wr    <= d_wr;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (if_req) begin
                if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
              end else begin
                starve_cnt <= '0;
              end
            end else begin
              // Fetch is read-only; mem_wdata keeps its previous value.
              owner      <= OWN_I;
              mem_wr     <= 1'b0;
              mem_addr   <= if_addr;
              starve_cnt <= '0;
            end
          end
        end
        GRANT: begin
          if (mem_data_valid) begin
            state  <= RESP;
            mem_en <= 1'b0;
            if (owner == OWN_D) begin
              d_done <= 1'b1;
              // A write completion leaves the last read data in place.
              if (!mem_wr) d_rdata <= mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
